// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock, LSB slice first, N = WIDTH/DIGIT cycles per operation.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input (x - y - cin computed as x + ~y + ~cin).

module serial_adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);
    logic [DIGIT:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[DIGIT];
endmodule

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_co;
    logic [WIDTH-1:0] sum_full;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             accept, last;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction reuses the adder: x - y - cin == x + ~y + ~cin; cout=1 means no borrow.
    assign b_in = sub ? ~y : y;
    assign c_in = sub ? ~cin : cin;
`else
    assign b_in = y;
    assign c_in = cin;
`endif

    assign accept = (state_q == IDLE) && start;
    assign last   = (cnt_q == CW'(N - 1));
    assign busy   = (state_q == RUN);

    serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a   (a_q[DIGIT-1:0]),
        .b   (b_q[DIGIT-1:0]),
        .ci  (carry_q),
        .sum (slice_sum),
        .co  (slice_co)
    );

    // Completed slices enter from the top so the final slice lands in the MSBs.
    if (N == 1) begin : g_single
        assign sum_full = slice_sum;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] acc_q;
        logic [WIDTH-1:0]       cat;

        assign cat      = {slice_sum, acc_q};
        assign sum_full = cat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                acc_q <= '0;
            else if (state_q == RUN)
                acc_q <= cat[WIDTH-1:DIGIT];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= x;
                b_q     <= b_in;
                carry_q <= c_in;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= slice_co;
                cnt_q   <= cnt_q + CW'(1);
                if (last) begin
                    s    <= sum_full;
                    cout <= slice_co;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (DIGIT = 1, 4, 8) sharing operands, separate starts.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise the subtract mode.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [7:0] x = '0, y = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    wire  [2:0]      busy_v, done_v, cout_v;
    wire  [2:0][7:0] s_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x(x), .y(y), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x(x), .y(y), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .x(x), .y(y), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One operation on instance i; checks acceptance, latency, single-cycle done, and the result.
    task automatic op(input int i, input logic [7:0] xv, input logic [7:0] yv, input logic cv,
                      input logic [7:0] exp_s, input logic exp_c, input int exp_lat);
        int lat;
        @(negedge clk);
        x = xv; y = yv; cin = cv; start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        chk("busy_after_accept", busy_v[i], 1);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done_v[i]) break;
        end
        chk("latency", lat, exp_lat);
        chk("busy_in_done", busy_v[i], 0);
        chk("sum", s_v[i], exp_s);
        chk("cout", cout_v[i], exp_c);
        @(negedge clk);
        chk("done_one_cycle", done_v[i], 0);
        chk("sum_hold", s_v[i], exp_s);
    endtask

    initial begin
        logic [7:0] vals [3];
        logic [8:0] r;
        int         dn;

        vals[0] = 8'h00; vals[1] = 8'h01; vals[2] = 8'hFF;

        #12;
        chk("rst_busy", busy_v, 0);
        chk("rst_done", done_v, 0);
        chk("rst_s", s_v[0], 0);
        chk("rst_cout", cout_v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Corner sweep on the bit-serial instance
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                for (int c = 0; c < 2; c++) begin
                    r = {1'b0, vals[a]} + {1'b0, vals[b]} + 9'(c);
                    op(0, vals[a], vals[b], c[0], r[7:0], r[8], 8);
                end

        op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
        op(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8);

        // Start during RUN is ignored; operand changes after acceptance have no effect
        @(negedge clk);
        x = 8'h12; y = 8'h34; cin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        x = 8'h77; y = 8'h77; cin = 1'b1;
        dn = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (done_v[0] && cyc < 8) dn++;
            start_v[0] = (cyc == 2);
            if (cyc == 2) begin x = 8'h55; y = 8'h66; end
        end
        chk("ignore_done_early", dn, 0);
        chk("ignore_done", done_v[0], 1);
        chk("ignore_sum", s_v[0], 8'h46);
        chk("ignore_cout", cout_v[0], 0);
        // Start held in the done cycle is accepted
        x = 8'hF0; y = 8'h0F; cin = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_busy", busy_v[0], 1);
        chk("b2b_no_done", done_v[0], 0);
        dn = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (done_v[0] && cyc < 8) dn++;
        end
        chk("b2b_done_early", dn, 0);
        chk("b2b_done", done_v[0], 1);
        chk("b2b_sum", s_v[0], 8'h00);
        chk("b2b_cout", cout_v[0], 1);

        // Reset mid-operation aborts with no done pulse
        op(0, 8'h20, 8'h03, 1'b0, 8'h23, 1'b0, 8);
        @(negedge clk);
        x = 8'h11; y = 8'h22; cin = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_s", s_v[0], 0);
        chk("abort_cout", cout_v[0], 0);
        dn = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done_v[0]) dn++;
            if (cyc == 1) rst_n = 1'b1;
        end
        chk("abort_no_done", dn, 0);
        op(0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 8);

        // Wider digits
        op(1, 8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 2);
        op(1, 8'h9A, 8'h47, 1'b1, 8'hE2, 1'b0, 2);
        op(2, 8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1);
        op(2, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        op(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 8);
        op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 8);
        op(1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 2);
        sub = 1'b0;
        op(0, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1, meaning a request to begin an addition.
REQ-006 The module SHALL have port x, input, WIDTH, meaning operand A.
REQ-007 The module SHALL have port y, input, WIDTH, meaning operand B.
REQ-008 The module SHALL have port cin, input, 1, meaning carry-in to bit 0.
REQ-009 The module SHALL have port busy, output, 1, meaning an addition is in progress.
REQ-010 The module SHALL have port done, output, 1, meaning a one-cycle pulse that s and cout were just updated.
REQ-011 The module SHALL have port s, output, WIDTH, meaning the sum of the last completed operation.
REQ-012 The module SHALL have port cout, output, 1, meaning the carry-out of the last completed operation.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and RUN; IDLE->RUN on start=1, and RUN->IDLE after the last digit.
REQ-014 In IDLE, a rising edge with start=1 SHALL latch x, y and cin into internal registers and clear the digit counter.
REQ-015 RUN SHALL last exactly N=WIDTH/DIGIT cycles; each cycle SHALL add one DIGIT-bit slice, LSB slice first, through a DIGIT-bit full-adder chain with the carry held in a 1-bit register between cycles.
REQ-016 If start is accepted at edge k, then busy SHALL be 1 from edge k to edge k+N, and s, cout and done=1 SHALL appear after edge k+N (latency N).
REQ-017 done SHALL be high for exactly one cycle per operation; busy SHALL be 0 in that same cycle.
REQ-018 start while busy=1 SHALL be ignored, and changes to x, y and cin after acceptance SHALL NOT affect the result.
REQ-019 start=1 in the done cycle SHALL be accepted (FSM is in IDLE), giving back-to-back operations with one idle-state cycle between RUN phases.
REQ-020 s and cout SHALL hold their values between done pulses and SHALL update only on completion.
REQ-021 Arithmetic SHALL be {cout,s} = x + y + cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-022 With DIGIT=WIDTH, N SHALL be 1 and the block SHALL still obey REQ-016 and REQ-017.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, s=0, cout=0, and clear the counter and carry register, independent of clk.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-025 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add an input port sub (1 bit) latched with the operands.
REQ-026 When sub=1 is latched, the block SHALL compute x - y - cin as x + ~y + ~cin; cout=1 SHALL mean no borrow.
REQ-027 When sub=0 is latched, or the macro is undefined, the block SHALL add per REQ-021; without the macro the sub port SHALL NOT exist.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-028 Sweep x,y,cin over {0x00,0x01,0xFF}x{0x00,0x01,0xFF}x{0,1} -> each result equals x+y+cin; done exactly 8 cycles after start acceptance.
REQ-029 x=0xFF, y=0x01, cin=0 -> s=0x00, cout=1; x=0xA5, y=0x5A, cin=1 -> s=0x00, cout=1.
REQ-030 start pulsed again at cycle 3 of RUN with different operands -> ignored, first result unchanged, one done pulse; start held high in the done cycle -> second operation accepted.
REQ-031 rst_n low at cycle 4 of RUN -> busy=0, s=0, cout=0 immediately, no done; next start -> correct result.
REQ-032 DIGIT=4, x=0x3C, y=0xC4, cin=0 -> s=0x00, cout=1, done 2 cycles after acceptance; DIGIT=8 -> done 1 cycle after acceptance.
REQ-033 With SERIAL_ADDER_SUB_EN defined: sub=1, x=0x10, y=0x01, cin=0 -> s=0x0F, cout=1; x=0x00, y=0x01 -> s=0xFF, cout=0.
